// File: rtl/pic_pkg.sv
// Shared definitions for the PIC core: default sizing, trigger-mode
// encoding and the fixed-priority encoder used by request and in-service logic.
package pic_pkg;

    localparam int NUM_IR_DEF      = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int MAX_IR          = 32;

    localparam logic TRIG_EDGE  = 1'b0;
    localparam logic TRIG_LEVEL = 1'b1;

    // Width of a channel index; at least one bit even for a single channel.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Fixed priority, bit 0 highest: index of the lowest set bit, 0 if none.
    function automatic logic [4:0] prio_enc(input logic [MAX_IR-1:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = MAX_IR - 1; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ir_sync.sv
// Single-bit multi-flop synchroniser for one asynchronous IR pin.
module ir_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // Shift the raw pin through the chain; only the last stage is used.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ff <= '0;
        else          ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/irq_request_reg.sv
// Interrupt request register: synchronises IR pins, latches edge/level
// requests per channel, holds them during acknowledge (freeze) and presents
// the highest-priority unmasked pending request.
module irq_request_reg
    import pic_pkg::*;
#(
    parameter int NUM_IR      = NUM_IR_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int IDW         = id_width(NUM_IR)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_IR-1:0] ir_in,
    input  logic [NUM_IR-1:0] ltim,
    input  logic [NUM_IR-1:0] imr,
    input  logic              freeze,
    input  logic              ack_valid,
    input  logic [IDW-1:0]    ack_id,
    output logic [NUM_IR-1:0] irr,
    output logic              int_req,
    output logic [IDW-1:0]    int_id
);

    logic [NUM_IR-1:0] s;
    logic [NUM_IR-1:0] prev;
    logic [NUM_IR-1:0] pend;
    logic [NUM_IR-1:0] rise;
    logic [NUM_IR-1:0] ack_vec;
    logic [NUM_IR-1:0] irr_next;
    logic [NUM_IR-1:0] pend_next;
    logic [NUM_IR-1:0] v;

    for (genvar g = 0; g < NUM_IR; g++) begin : g_sync
        ir_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .d       (ir_in[g]),
            .q       (s[g])
        );
    end

    assign rise = s & ~prev;
    assign v    = irr & ~imr;

    // One-hot acknowledge; ids beyond the last channel decode to nothing.
    always_comb begin
        ack_vec = '0;
        for (int i = 0; i < NUM_IR; i++) begin
            ack_vec[i] = ack_valid && (int'(ack_id) == i);
        end
    end

    // Per-channel request update; freeze defers sets and withdrawals but not acks.
    always_comb begin
        irr_next  = irr;
        pend_next = pend;
        for (int i = 0; i < NUM_IR; i++) begin
            if (freeze) begin
                if (rise[i])    pend_next[i] = 1'b1;
                if (ack_vec[i]) irr_next[i]  = 1'b0;
            end else begin
                pend_next[i] = 1'b0;
                if (ltim[i] == TRIG_EDGE) begin
                    // A new edge beats a same-cycle ack so the request is not lost.
                    if (rise[i] || (pend[i] && s[i])) irr_next[i] = 1'b1;
                    else if (!s[i] || ack_vec[i])     irr_next[i] = 1'b0;
                end else begin
                    irr_next[i] = s[i] & ~ack_vec[i];
                end
            end
        end
    end

    // Edge history, pending-edge latch and request register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= '0;
            pend <= '0;
            irr  <= '0;
        end else begin
            prev <= s;
            pend <= pend_next;
            irr  <= irr_next;
        end
    end

    // Registered priority result presented to the control logic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            int_req <= 1'b0;
            int_id  <= '0;
        end else begin
            int_req <= |v;
            int_id  <= IDW'(prio_enc(MAX_IR'(v)));
        end
    end

endmodule

// File: tb/tb_irq_request_reg.sv
// Directed bench for irq_request_reg: per-cycle vector table on the default
// 8-channel instance plus short sequences on 16- and 5-channel instances.
module tb_irq_request_reg;

    logic clk;
    logic reset_n;

    // 8 channels, 2 sync stages
    logic [7:0] ir_in, ltim, imr, irr;
    logic       freeze, ack_valid, int_req;
    logic [2:0] ack_id, int_id;

    // 16 channels, 3 sync stages
    logic [15:0] ir16, irr16;
    logic [3:0]  id16;
    logic        req16;

    // 5 channels, index width 3 (ids 5..7 are out of range)
    logic [4:0] ir5, irr5;
    logic       av5, req5;
    logic [2:0] aid5, id5;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] ir;
        logic [7:0] ltim;
        logic [7:0] imr;
        logic       frz;
        logic       av;
        logic [2:0] aid;
        logic [7:0] e_irr;
        logic       e_req;
        logic [2:0] e_id;
    } vec_t;

    vec_t tbl[$];

    irq_request_reg u_dut (
        .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .ltim(ltim), .imr(imr),
        .freeze(freeze), .ack_valid(ack_valid), .ack_id(ack_id),
        .irr(irr), .int_req(int_req), .int_id(int_id)
    );

    irq_request_reg #(.NUM_IR(16), .SYNC_STAGES(3)) u_p16 (
        .clk(clk), .reset_n(reset_n), .ir_in(ir16), .ltim(16'h0000), .imr(16'h0000),
        .freeze(1'b0), .ack_valid(1'b0), .ack_id(4'h0),
        .irr(irr16), .int_req(req16), .int_id(id16)
    );

    irq_request_reg #(.NUM_IR(5), .SYNC_STAGES(2)) u_p5 (
        .clk(clk), .reset_n(reset_n), .ir_in(ir5), .ltim(5'h00), .imr(5'h00),
        .freeze(1'b0), .ack_valid(av5), .ack_id(aid5),
        .irr(irr5), .int_req(req5), .int_id(id5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1);
    end

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0h, want %0h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [7:0] ir, input logic [7:0] lt,
                                input logic [7:0] im, input logic frz,
                                input logic av, input logic [2:0] aid,
                                input logic [7:0] e_irr, input logic e_req,
                                input logic [2:0] e_id);
        vec_t r;
        r.ir = ir; r.ltim = lt; r.imr = im; r.frz = frz; r.av = av; r.aid = aid;
        r.e_irr = e_irr; r.e_req = e_req; r.e_id = e_id;
        return r;
    endfunction

    initial begin
        // Each row: inputs held for one edge, expected outputs just after it.
        //                ir     ltim   imr   frz av aid  irr   req id
        // edge latency and withdraw
        tbl.push_back(mk(8'h08, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h08, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h08, 8'h00, 8'h00, 0, 0, 0, 8'h08, 0, 0));
        tbl.push_back(mk(8'h08, 8'h00, 8'h00, 0, 0, 0, 8'h08, 1, 3));
        tbl.push_back(mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h08, 1, 3));
        tbl.push_back(mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h08, 1, 3));
        tbl.push_back(mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 3));
        tbl.push_back(mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        // priority and mask
        tbl.push_back(mk(8'h24, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h24, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h24, 8'h00, 8'h00, 0, 0, 0, 8'h24, 0, 0));
        tbl.push_back(mk(8'h24, 8'h00, 8'h00, 0, 0, 0, 8'h24, 1, 2));
        tbl.push_back(mk(8'h24, 8'h00, 8'h04, 0, 0, 0, 8'h24, 1, 5));
        tbl.push_back(mk(8'h24, 8'h00, 8'h04, 0, 1, 5, 8'h04, 1, 5));
        tbl.push_back(mk(8'h24, 8'h00, 8'h04, 0, 0, 0, 8'h04, 0, 0));
        tbl.push_back(mk(8'h24, 8'h00, 8'h00, 0, 0, 0, 8'h04, 1, 2));
        tbl.push_back(mk(8'h00, 8'h00, 8'h00, 0, 1, 2, 8'h00, 1, 2));
        tbl.push_back(mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        // same-cycle rise and ack: set wins
        tbl.push_back(mk(8'h02, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h02, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h02, 8'h00, 8'h00, 0, 1, 1, 8'h02, 0, 0));
        tbl.push_back(mk(8'h02, 8'h00, 8'h00, 0, 0, 0, 8'h02, 1, 1));
        tbl.push_back(mk(8'h02, 8'h00, 8'h00, 0, 1, 1, 8'h00, 1, 1));
        tbl.push_back(mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        // level mode with ack
        tbl.push_back(mk(8'h01, 8'h01, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h01, 8'h01, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h01, 8'h01, 8'h00, 0, 0, 0, 8'h01, 0, 0));
        tbl.push_back(mk(8'h01, 8'h01, 8'h00, 0, 1, 0, 8'h00, 1, 0));
        tbl.push_back(mk(8'h01, 8'h01, 8'h00, 0, 0, 0, 8'h01, 0, 0));
        tbl.push_back(mk(8'h00, 8'h01, 8'h00, 0, 0, 0, 8'h01, 1, 0));
        tbl.push_back(mk(8'h00, 8'h01, 8'h00, 0, 0, 0, 8'h01, 1, 0));
        tbl.push_back(mk(8'h00, 8'h01, 8'h00, 0, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(8'h00, 8'h01, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        // trigger-mode switching
        tbl.push_back(mk(8'h10, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h10, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h10, 8'h00, 8'h00, 0, 0, 0, 8'h10, 0, 0));
        tbl.push_back(mk(8'h10, 8'h00, 8'h00, 0, 1, 4, 8'h00, 1, 4));
        tbl.push_back(mk(8'h10, 8'h10, 8'h00, 0, 0, 0, 8'h10, 0, 0));
        tbl.push_back(mk(8'h10, 8'h00, 8'h00, 0, 0, 0, 8'h10, 1, 4));
        tbl.push_back(mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h10, 1, 4));
        tbl.push_back(mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h10, 1, 4));
        tbl.push_back(mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 4));
        tbl.push_back(mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        // freeze: deferred set, held withdraw, ack still clears
        tbl.push_back(mk(8'h40, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h40, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h40, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h40, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(8'h40, 8'h00, 8'h00, 0, 0, 0, 8'h40, 0, 0));
        tbl.push_back(mk(8'h40, 8'h00, 8'h00, 0, 0, 0, 8'h40, 1, 6));
        tbl.push_back(mk(8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h40, 1, 6));
        tbl.push_back(mk(8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h40, 1, 6));
        tbl.push_back(mk(8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h40, 1, 6));
        tbl.push_back(mk(8'h00, 8'h00, 8'h00, 1, 1, 6, 8'h00, 1, 6));
        tbl.push_back(mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0));

        // Reset with all request lines high
        reset_n = 1'b0;
        ir_in = 8'hFF; ltim = 8'h00; imr = 8'h00;
        freeze = 1'b0; ack_valid = 1'b0; ack_id = 3'd0;
        ir16 = 16'hFFFF; ir5 = 5'h1F; av5 = 1'b0; aid5 = 3'd0;
        repeat (3) step();
        check("reset irr", 0, 32'(irr), 32'h0);
        check("reset int_req", 0, 32'(int_req), 32'h0);
        check("reset int_id", 0, 32'(int_id), 32'h0);
        check("reset irr16", 0, 32'(irr16), 32'h0);
        ir_in = 8'h00; ir16 = 16'h0000; ir5 = 5'h00;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) step();

        // Vector table on the 8-channel instance
        for (int r = 0; r < tbl.size(); r++) begin
            ir_in     = tbl[r].ir;
            ltim      = tbl[r].ltim;
            imr       = tbl[r].imr;
            freeze    = tbl[r].frz;
            ack_valid = tbl[r].av;
            ack_id    = tbl[r].aid;
            step();
            check("irr", r, 32'(irr), 32'(tbl[r].e_irr));
            check("int_req", r, 32'(int_req), 32'(tbl[r].e_req));
            check("int_id", r, 32'(int_id), 32'(tbl[r].e_id));
        end
        ir_in = 8'h00; ltim = 8'h00; imr = 8'h00;
        freeze = 1'b0; ack_valid = 1'b0; ack_id = 3'd0;

        // 16 channels, 3 stages: irr after 4 edges, int_req/int_id after 5
        ir16 = 16'h8000;
        for (int e = 1; e <= 5; e++) begin
            step();
            check("p16 irr", e, 32'(irr16), (e >= 4) ? 32'h8000 : 32'h0);
            if (e == 4) check("p16 int_req", e, 32'(req16), 32'h0);
            if (e == 5) begin
                check("p16 int_req", e, 32'(req16), 32'h1);
                check("p16 int_id", e, 32'(id16), 32'd15);
            end
        end
        ir16 = 16'h0000;

        // 5 channels: out-of-range ack ignored, valid ack clears
        ir5 = 5'h10;
        repeat (3) step();
        check("p5 irr set", 3, 32'(irr5), 32'h10);
        av5 = 1'b1; aid5 = 3'd6;
        step();
        check("p5 irr bad ack", 4, 32'(irr5), 32'h10);
        check("p5 int_req", 4, 32'(req5), 32'h1);
        check("p5 int_id", 4, 32'(id5), 32'd4);
        aid5 = 3'd4;
        step();
        check("p5 irr ack", 5, 32'(irr5), 32'h00);
        av5 = 1'b0; aid5 = 3'd0; ir5 = 5'h00;
        repeat (3) step();

        // Reset asserted mid-freeze clears everything at once
        ir_in = 8'h01;
        repeat (3) step();
        check("pre-frz irr", 0, 32'(irr), 32'h01);
        ir_in = 8'h41; freeze = 1'b1;
        repeat (3) step();
        check("frz irr held", 0, 32'(irr), 32'h01);
        check("frz int_req", 0, 32'(int_req), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async rst irr", 0, 32'(irr), 32'h0);
        check("async rst int_req", 0, 32'(int_req), 32'h0);
        ir_in = 8'h00; freeze = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) step();
        check("post-rst irr", 0, 32'(irr), 32'h0);
        check("post-rst int_req", 0, 32'(int_req), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
